// File: rtl/regdata_wb_sequencer.sv
// regdata_wb_sequencer
//   Registered write-back data selector and sequencer for the multicycle CPU
//   register file. A request picks one of N_SRC channels (or the built-in
//   constant) and drives one register-file write on the next cycle. A swap
//   request also issues a second write in the cycle after that, using the
//   swap data and destination captured when the request was accepted.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   src_bus             : flattened sources, channel k = [k*DATA_W +: DATA_W]
//   sel                 : source select (CONST_SEL returns CONST_VAL)
//   req_valid/req_ready : request handshake, accept = valid && ready
//   dst_a, dst_b        : destinations of first / second (swap) write
//   swap, swap_data     : two-write request and the data for its second write
//   wb_en/wb_addr/wb_data : register-file write port (address 0 never written)
//   sel_err             : one-cycle pulse after an accept with an invalid sel
module regdata_wb_sequencer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned N_SRC     = 10,
  parameter int unsigned SEL_W     = 4,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned CONST_SEL = 6,
  parameter int unsigned CONST_VAL = 227
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_SRC*DATA_W-1:0] src_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       dst_a,
  input  logic                    swap,
  input  logic [DATA_W-1:0]       swap_data,
  input  logic [ADDR_W-1:0]       dst_b,
  output logic                    wb_en,
  output logic [ADDR_W-1:0]       wb_addr,
  output logic [DATA_W-1:0]       wb_data,
  output logic                    sel_err
);

  if ((1 << SEL_W) <= N_SRC) begin : g_param_check
    $fatal(1, "regdata_wb_sequencer: 2**SEL_W must exceed N_SRC");
  end

  typedef enum logic {
    IDLE,
    SWAP_B
  } state_t;

  state_t              state, state_nx;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_ok;
  logic                accept;
  logic                capture;
  logic [DATA_W-1:0]   swap_q;
  logic [ADDR_W-1:0]   dstb_q;
  logic                en_nx;
  logic                err_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic [DATA_W-1:0]   data_nx;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // Constant code wins even when it also names a real channel.
  always_comb begin
    sel_data = '0;
    sel_ok   = 1'b0;
    if (sel == SEL_W'(CONST_SEL)) begin
      sel_data = DATA_W'(CONST_VAL);
      sel_ok   = 1'b1;
    end else begin
      for (int unsigned k = 0; k < N_SRC; k++) begin
        if (sel == SEL_W'(k)) begin
          sel_data = src_bus[k*DATA_W +: DATA_W];
          sel_ok   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    en_nx    = 1'b0;
    err_nx   = 1'b0;
    addr_nx  = wb_addr;
    data_nx  = wb_data;
    capture  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          addr_nx = dst_a;
          if (sel_ok) begin
            data_nx = sel_data;
            en_nx   = (dst_a != '0);
            if (swap) begin
              capture  = 1'b1;
              state_nx = SWAP_B;
            end
          end else begin
            data_nx = '0;
            err_nx  = 1'b1;
          end
        end
      end
      SWAP_B: begin
        addr_nx  = dstb_q;
        data_nx  = swap_q;
        en_nx    = (dstb_q != '0);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      sel_err <= 1'b0;
    end else begin
      wb_en   <= en_nx;
      wb_addr <= addr_nx;
      wb_data <= data_nx;
      sel_err <= err_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      swap_q <= '0;
      dstb_q <= '0;
    end else if (capture) begin
      swap_q <= swap_data;
      dstb_q <= dst_b;
    end
  end

endmodule

// File: tb/tb_regdata_wb_sequencer.sv
// Scoreboard bench for regdata_wb_sequencer: the driver applies inputs on the
// falling edge, predicts the registered outputs from a behavioural model and
// queues them; the monitor pops one prediction after every rising edge.
module tb_regdata_wb_sequencer;

  localparam int DW = 32;
  localparam int NS = 10;
  localparam int SW = 4;
  localparam int AW = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [NS*DW-1:0] src_bus;
  logic [SW-1:0]    sel;
  logic             req_valid;
  logic             req_ready;
  logic [AW-1:0]    dst_a;
  logic             swap;
  logic [DW-1:0]    swap_data;
  logic [AW-1:0]    dst_b;
  logic             wb_en;
  logic [AW-1:0]    wb_addr;
  logic [DW-1:0]    wb_data;
  logic             sel_err;

  regdata_wb_sequencer #(
    .DATA_W(DW), .N_SRC(NS), .SEL_W(SW), .ADDR_W(AW),
    .CONST_SEL(6), .CONST_VAL(227)
  ) dut (
    .clk(clk), .reset(reset), .src_bus(src_bus), .sel(sel),
    .req_valid(req_valid), .req_ready(req_ready), .dst_a(dst_a),
    .swap(swap), .swap_data(swap_data), .dst_b(dst_b),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          err;
    logic          ready;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  logic [DW-1:0] ch [NS];

  // Reference model state: an optional pending second write and the held outputs.
  bit            pend;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_data;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wb_en",     DW'(wb_en),     DW'(e.en));
        chk("wb_addr",   DW'(wb_addr),   DW'(e.addr));
        chk("wb_data",   wb_data,        e.data);
        chk("sel_err",   DW'(sel_err),   DW'(e.err));
        chk("req_ready", DW'(req_ready), DW'(e.ready));
      end
    end
  end

  task automatic cyc(input bit r, input bit v, input int s, input int da,
                     input bit sw, input logic [DW-1:0] sd, input int db);
    exp_t e;
    logic [DW-1:0] d;
    bit ok;
    @(negedge clk);
    reset = r; req_valid = v; sel = SW'(s); dst_a = AW'(da);
    swap = sw; swap_data = sd; dst_b = AW'(db);
    for (int k = 0; k < NS; k++) src_bus[k*DW +: DW] = ch[k];

    e = '0;
    if (r) begin
      pend = 0; last_addr = '0; last_data = '0;
    end else if (pend) begin
      last_addr = pend_addr; last_data = pend_data;
      e.en = (pend_addr != 0);
      pend = 0;
    end else if (v) begin
      ok = 1;
      if (s == 6) d = 227;
      else if (s < NS) d = ch[s];
      else ok = 0;
      last_addr = AW'(da);
      if (ok) begin
        last_data = d;
        e.en = (da != 0);
        if (sw) begin
          pend = 1; pend_addr = AW'(db); pend_data = sd;
        end
      end else begin
        last_data = '0;
        e.err = 1;
      end
    end
    e.addr  = last_addr;
    e.data  = last_data;
    e.ready = !r && !pend;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    cyc(0, 0, $urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 1),
        $urandom, $urandom_range(0, 31));
  endtask

  initial begin : driver
    int budget;
    pend = 0; last_addr = '0; last_data = '0;
    for (int k = 0; k < NS; k++) ch[k] = $urandom;
    reset = 1; req_valid = 0; sel = '0; dst_a = '0; swap = 0;
    swap_data = '0; dst_b = '0; src_bus = '0;

    // 1: reset, then a single write from channel 0
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    ch[0] = 32'h1234_5678;
    cyc(0, 1, 0, 8, 0, 0, 0);
    idle();
    // 2: constant select overrides channel 6, then an invalid select
    ch[6] = 32'hFFFF_FFFF;
    cyc(0, 1, 6, 3, 0, 0, 0);
    cyc(0, 1, 11, 5, 1, 32'hDEAD_BEEF, 7);
    idle();
    idle();
    // 3: swap with inputs scrambled during the second-write cycle
    ch[7] = 32'hAAAA_0001;
    cyc(0, 1, 7, 9, 1, 32'h5555_0002, 10);
    for (int k = 0; k < NS; k++) ch[k] = $urandom;
    cyc(0, 1, 2, 17, 1, 32'h0BAD_F00D, 18);
    cyc(0, 1, 1, 12, 0, 0, 0);
    // 4: back-to-back writes
    cyc(0, 1, 1, 1, 0, 0, 0);
    cyc(0, 1, 2, 2, 0, 0, 0);
    cyc(0, 1, 3, 3, 0, 0, 0);
    idle();
    // 5: swap whose first destination is r0
    cyc(0, 1, 4, 0, 1, 32'hCAFE_0004, 4);
    idle();
    idle();
    // 6: reset during the second-write cycle
    cyc(0, 1, 5, 6, 1, 32'h7777_0006, 11);
    cyc(1, 1, 5, 6, 1, 32'h7777_0006, 11);
    idle();
    idle();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NS; k++) ch[k] = $urandom;
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7),
          $urandom_range(0, 15),
          ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31),
          ($urandom_range(0, 9) < 3), $urandom,
          ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31));
    end

    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      #3;
      budget--;
    end
    total++;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regdata_wb_sequencer.md
Name: regdata_wb_sequencer

Overview:
Registered, parametrised write-back data selector and sequencer for the multicycle CPU register file.
- Selects one of N_SRC data sources, or a built-in constant, and registers the result.
- Issues register-file write strobes with destination addresses.
- Supports a two-write "swap" transaction (XCHG-style: both registers written on consecutive cycles) without extra control-unit states.
- Sits between the datapath source registers and the register bank write port.

Parameters:
DATA_W, 32, width of each source and of wb_data
N_SRC, 10, number of source channels on src_bus
SEL_W, 4, width of sel; requires 2^SEL_W > N_SRC
ADDR_W, 5, register address width
CONST_SEL, 6, sel code that returns CONST_VAL instead of a channel
CONST_VAL, 227, constant driven when sel == CONST_SEL

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
src_bus  in  N_SRC*DATA_W  flattened sources; channel k = bits [k*DATA_W +: DATA_W]
sel  in  SEL_W  source select
req_valid  in  1  write request present
req_ready  out  1  sequencer can accept a request this cycle
dst_a  in  ADDR_W  destination of first (or only) write
swap  in  1  request is a two-write transaction
swap_data  in  DATA_W  data for second write
dst_b  in  ADDR_W  destination of second write
wb_en  out  1  register-file write enable
wb_addr  out  ADDR_W  write address
wb_data  out  DATA_W  write data
sel_err  out  1  one-cycle pulse: accepted request had invalid sel

Behaviour:
- Reset (reset=1 at clk edge):
  - state=IDLE; wb_en=0, wb_addr=0, wb_data=0, sel_err=0.
  - Any pending second write is discarded.
  - req_ready is 0 while reset is high and 1 in the first cycle after it goes low.
- States: IDLE, SWAP_B.
- req_ready=1 in IDLE, 0 in SWAP_B (combinational from state and reset).
- Accept = req_valid && req_ready.
- Source selection at accept:
  - sel == CONST_SEL → CONST_VAL zero-extended to DATA_W. This takes priority even if CONST_SEL < N_SRC.
  - Otherwise sel < N_SRC → channel sel.
  - Otherwise invalid sel.
- IDLE, accept, valid sel, swap=0:
  - Next cycle: wb_en=1, wb_addr=dst_a, wb_data=selected. Latency 1.
  - Stay in IDLE.
  - Back-to-back accepts each cycle give a continuous wb_en stream.
- IDLE, accept, valid sel, swap=1:
  - Next cycle: first write as above.
  - swap_data and dst_b are captured at accept into internal registers.
  - Go to SWAP_B.
- SWAP_B, one cycle:
  - Next cycle: wb_en=1, wb_addr=captured dst_b, wb_data=captured swap_data.
  - Return to IDLE.
  - req_valid is ignored; inputs changing during SWAP_B do not affect the second write.
- Invalid sel at accept:
  - Next cycle: wb_en=0, wb_data=0, wb_addr=dst_a, sel_err=1.
  - No swap second write is issued; state stays IDLE.
- Destination 0:
  - Any write whose address is 0 is suppressed (wb_en=0); wb_data and wb_addr still update.
  - Sequencing is unaffected: a swap with dst_a=0 still writes dst_b in the following cycle.
- No accept (IDLE, req_valid=0):
  - Next cycle: wb_en=0, sel_err=0.
  - wb_addr and wb_data hold their previous values.
- sel_err is high only in the cycle after an invalid accept; it never stays high.
- Reset mid-swap: reset asserted while in SWAP_B → the following cycle has wb_en=0, and dst_b is never written.
- Data registers are DATA_W wide; no arithmetic, no truncation except CONST_VAL zero-extension.
- Illegal parameters (2^SEL_W <= N_SRC) are flagged by a simulation-time check.

Test Plan:
1. Reset, then sel=0, ch0=0x1234_5678, dst_a=8, one-cycle valid → next cycle wb_en=1, wb_addr=8, wb_data=0x1234_5678; cycle after: wb_en=0.
2. sel=6 with ch6=0xFFFF_FFFF, dst_a=3 → wb_data=0x0000_00E3 (227), wb_en=1; then sel=11 → wb_en=0, sel_err=1 for exactly one cycle.
3. swap=1, sel=7, ch7=0xAAAA_0001, dst_a=9, swap_data=0x5555_0002, dst_b=10; drive new values on all inputs during SWAP_B → cycle+1: (9, 0xAAAA_0001); cycle+2: (10, 0x5555_0002); req_ready=0 during SWAP_B; next request accepted the cycle after.
4. Three back-to-back non-swap requests to regs 1, 2, 3 → three consecutive wb_en pulses carrying the matching data, req_ready constantly 1.
5. swap with dst_a=0, dst_b=4 → first cycle wb_en=0; second cycle wb_en=1, wb_addr=4.
6. swap accepted, then reset asserted in SWAP_B → no write to dst_b; after release, wb_en=0, wb_data=0, req_ready=1.
